// File: rtl/reg_rename_file.sv
// Architectural register file with a per-register rename (busy/tag) table.
// Two combinational lookup ports see the ROB commit bus bypassed in the same cycle.
module reg_rename_file #(
   parameter int REG_NUM    = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ROB_TAG_W  = 5,
   parameter int XLEN       = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,
   input  logic                  commit_en_in,
   input  logic [ROB_TAG_W-1:0]  commit_tag_in,
   input  logic [REG_ADDR_W-1:0] commit_rd_in,
   input  logic [XLEN-1:0]       commit_val_in,
   input  logic                  rename_en_in,
   input  logic [REG_ADDR_W-1:0] rename_rd_in,
   input  logic [ROB_TAG_W-1:0]  rename_tag_in,
   input  logic [REG_ADDR_W-1:0] rs1_addr_in,
   input  logic [REG_ADDR_W-1:0] rs2_addr_in,
   output logic [XLEN-1:0]       rs1_val_out,
   output logic                  rs1_busy_out,
   output logic [ROB_TAG_W-1:0]  rs1_tag_out,
   output logic [XLEN-1:0]       rs2_val_out,
   output logic                  rs2_busy_out,
   output logic [ROB_TAG_W-1:0]  rs2_tag_out
);

   typedef struct packed {
      logic [XLEN-1:0]      val;
      logic                 busy;
      logic [ROB_TAG_W-1:0] tag;
   } lookup_t;

   logic [XLEN-1:0]      val_q  [REG_NUM];
   logic                 busy_q [REG_NUM];
   logic [ROB_TAG_W-1:0] tag_q  [REG_NUM];

   logic commit_hit;
   logic rename_hit;
   lookup_t rs1_res;
   lookup_t rs2_res;

   assign commit_hit = commit_en_in && (commit_rd_in != '0);
   assign rename_hit = rename_en_in && (rename_rd_in != '0) && !clear_in;

   // Rename is applied after commit so it wins busy/tag on a same-register collision.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_q[i]  <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (commit_hit) begin
            val_q[commit_rd_in] <= commit_val_in;
            if (busy_q[commit_rd_in] && (tag_q[commit_rd_in] == commit_tag_in)) begin
               busy_q[commit_rd_in] <= 1'b0;
            end
         end
         if (clear_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
               busy_q[i] <= 1'b0;
            end
         end else if (rename_hit) begin
            busy_q[rename_rd_in] <= 1'b1;
            tag_q[rename_rd_in]  <= rename_tag_in;
         end
      end
   end

   // A pending operand resolves immediately when its own producer commits this cycle.
   function automatic lookup_t lookup(input logic [REG_ADDR_W-1:0] rs);
      lookup_t r;
      r.val  = '0;
      r.busy = 1'b0;
      r.tag  = '0;
      if (rs != '0) begin
         r.val = val_q[rs];
         r.tag = tag_q[rs];
         if (busy_q[rs]) begin
            if (commit_en_in && (commit_rd_in == rs) && (commit_tag_in == tag_q[rs])) begin
               r.val = commit_val_in;
            end else begin
               r.busy = 1'b1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      rs1_res = lookup(rs1_addr_in);
   end

   always_comb begin
      rs2_res = lookup(rs2_addr_in);
   end

   assign rs1_val_out  = rs1_res.val;
   assign rs1_busy_out = rs1_res.busy;
   assign rs1_tag_out  = rs1_res.tag;
   assign rs2_val_out  = rs2_res.val;
   assign rs2_busy_out = rs2_res.busy;
   assign rs2_tag_out  = rs2_res.tag;

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: expectations are queued per step and
// compared against the lookup outputs captured half a cycle away from the clock edge.
module tb_reg_rename_file;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        clear_in;
   logic        commit_en_in;
   logic [4:0]  commit_tag_in;
   logic [4:0]  commit_rd_in;
   logic [31:0] commit_val_in;
   logic        rename_en_in;
   logic [4:0]  rename_rd_in;
   logic [4:0]  rename_tag_in;
   logic [4:0]  rs1_addr_in;
   logic [4:0]  rs2_addr_in;
   logic [31:0] rs1_val_out;
   logic        rs1_busy_out;
   logic [4:0]  rs1_tag_out;
   logic [31:0] rs2_val_out;
   logic        rs2_busy_out;
   logic [4:0]  rs2_tag_out;

   always #5 clk_in = ~clk_in;

   reg_rename_file dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .clear_in      (clear_in),
      .commit_en_in  (commit_en_in),
      .commit_tag_in (commit_tag_in),
      .commit_rd_in  (commit_rd_in),
      .commit_val_in (commit_val_in),
      .rename_en_in  (rename_en_in),
      .rename_rd_in  (rename_rd_in),
      .rename_tag_in (rename_tag_in),
      .rs1_addr_in   (rs1_addr_in),
      .rs2_addr_in   (rs2_addr_in),
      .rs1_val_out   (rs1_val_out),
      .rs1_busy_out  (rs1_busy_out),
      .rs1_tag_out   (rs1_tag_out),
      .rs2_val_out   (rs2_val_out),
      .rs2_busy_out  (rs2_busy_out),
      .rs2_tag_out   (rs2_tag_out)
   );

   typedef struct packed {
      logic [31:0] v;
      logic        b;
      logic [4:0]  t;
   } port_obs_t;

   typedef struct packed {
      port_obs_t p1;
      port_obs_t p2;
   } step_obs_t;

   typedef struct {
      string       name;
      int          step;
      int          port;
      logic [31:0] val;
      logic        busy;
      logic [4:0]  tag;
      bit          chkVal;
      bit          chkTag;
   } exp_t;

   exp_t      sb[$];
   step_obs_t obs[$];
   int        vectors = 0;
   int        miscompares = 0;

   function automatic void snap();
      step_obs_t s;
      s.p1 = {rs1_val_out, rs1_busy_out, rs1_tag_out};
      s.p2 = {rs2_val_out, rs2_busy_out, rs2_tag_out};
      obs.push_back(s);
   endfunction

   function automatic void want(input string n, input int port, input logic [31:0] v,
                                input logic b, input logic [4:0] t, input bit cv, input bit ct);
      exp_t e;
      e.name = n; e.step = obs.size() - 1; e.port = port;
      e.val = v; e.busy = b; e.tag = t; e.chkVal = cv; e.chkTag = ct;
      sb.push_back(e);
   endfunction

   task automatic drive(input logic ce, input logic [4:0] ct, input logic [4:0] cr,
                        input logic [31:0] cv, input logic re, input logic [4:0] rr,
                        input logic [4:0] rt, input logic clr, input logic rdy,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk_in);
      commit_en_in = ce; commit_tag_in = ct; commit_rd_in = cr; commit_val_in = cv;
      rename_en_in = re; rename_rd_in = rr; rename_tag_in = rt;
      clear_in = clr; rdy_in = rdy; rs1_addr_in = a1; rs2_addr_in = a2;
      #1 snap();
   endtask

   task automatic look(input logic [4:0] a1, input logic [4:0] a2);
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, a1, a2);
   endtask

   task automatic test_reset();
      port_obs_t g;
      step_obs_t o;
      exp_t e;
      look(5'd5, 5'd31);
      want("por_rs1", 1, 32'h0, 1'b0, 5'd0, 1, 1);
      want("por_rs2", 2, 32'h0, 1'b0, 5'd0, 1, 1);
      @(negedge clk_in) rst_in = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 5'd6);
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd4, 1'b0, 1'b1, 5'd5, 5'd6);
      look(5'd5, 5'd6);
      want("pre_rst_x5", 1, 32'h0, 1'b1, 5'd3, 0, 1);
      want("pre_rst_x6", 2, 32'h0, 1'b1, 5'd4, 0, 1);
      @(negedge clk_in) rst_in = 1'b0;
      #1 snap();
      want("in_rst_x5", 1, 32'h0, 1'b0, 5'd0, 1, 1);
      want("in_rst_x6", 2, 32'h0, 1'b0, 5'd0, 1, 1);
      @(negedge clk_in) rst_in = 1'b1;
      look(5'd5, 5'd6);
      want("post_rst_x5", 1, 32'h0, 1'b0, 5'd0, 1, 0);
      want("post_rst_x6", 2, 32'h0, 1'b0, 5'd0, 1, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); o = obs[e.step];
         g = (e.port == 1) ? o.p1 : o.p2;
         vectors++;
         if (g.b !== e.busy || (e.chkVal && g.v !== e.val) || (e.chkTag && g.t !== e.tag)) begin
            miscompares++;
            $display("[TB] FAIL %s: got val=%h busy=%0b tag=%0d, want val=%h busy=%0b tag=%0d",
                     e.name, g.v, g.b, g.t, e.val, e.busy, e.tag);
         end
      end
      obs.delete();
   endtask

   task automatic test_rename_commit();
      port_obs_t g;
      step_obs_t o;
      exp_t e;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 5'd0);
      want("rename_no_bypass", 1, 32'h0, 1'b0, 5'd0, 1, 0);
      look(5'd5, 5'd0);
      want("renamed_busy", 1, 32'h0, 1'b1, 5'd3, 0, 1);
      drive(1'b1, 5'd3, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 5'd5);
      want("commit_bypass_rs1", 1, 32'hDEADBEEF, 1'b0, 5'd0, 1, 0);
      want("commit_bypass_rs2", 2, 32'hDEADBEEF, 1'b0, 5'd0, 1, 0);
      look(5'd5, 5'd0);
      want("commit_state", 1, 32'hDEADBEEF, 1'b0, 5'd0, 1, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); o = obs[e.step];
         g = (e.port == 1) ? o.p1 : o.p2;
         vectors++;
         if (g.b !== e.busy || (e.chkVal && g.v !== e.val) || (e.chkTag && g.t !== e.tag)) begin
            miscompares++;
            $display("[TB] FAIL %s: got val=%h busy=%0b tag=%0d, want val=%h busy=%0b tag=%0d",
                     e.name, g.v, g.b, g.t, e.val, e.busy, e.tag);
         end
      end
      obs.delete();
   endtask

   task automatic test_stale_commit();
      port_obs_t g;
      step_obs_t o;
      exp_t e;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd2, 1'b0, 1'b1, 5'd0, 5'd7);
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd9, 1'b0, 1'b1, 5'd0, 5'd7);
      want("first_rename_x7", 2, 32'h0, 1'b1, 5'd2, 0, 1);
      drive(1'b1, 5'd2, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd7);
      want("stale_no_bypass", 2, 32'h0, 1'b1, 5'd9, 0, 1);
      look(5'd0, 5'd7);
      want("stale_keeps_busy", 2, 32'h11, 1'b1, 5'd9, 1, 1);
      drive(1'b1, 5'd9, 5'd7, 32'h22, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd7);
      want("young_bypass", 2, 32'h22, 1'b0, 5'd0, 1, 0);
      look(5'd0, 5'd7);
      want("young_state", 2, 32'h22, 1'b0, 5'd0, 1, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); o = obs[e.step];
         g = (e.port == 1) ? o.p1 : o.p2;
         vectors++;
         if (g.b !== e.busy || (e.chkVal && g.v !== e.val) || (e.chkTag && g.t !== e.tag)) begin
            miscompares++;
            $display("[TB] FAIL %s: got val=%h busy=%0b tag=%0d, want val=%h busy=%0b tag=%0d",
                     e.name, g.v, g.b, g.t, e.val, e.busy, e.tag);
         end
      end
      obs.delete();
   endtask

   task automatic test_collision();
      port_obs_t g;
      step_obs_t o;
      exp_t e;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd1, 1'b0, 1'b1, 5'd4, 5'd0);
      drive(1'b1, 5'd1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd6, 1'b0, 1'b1, 5'd4, 5'd0);
      want("collide_bypass", 1, 32'h55, 1'b0, 5'd0, 1, 0);
      look(5'd4, 5'd0);
      want("collide_rename_wins", 1, 32'h55, 1'b1, 5'd6, 1, 1);
      drive(1'b1, 5'd6, 5'd4, 32'h66, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0);
      look(5'd4, 5'd4);
      want("collide_final_rs1", 1, 32'h66, 1'b0, 5'd0, 1, 0);
      want("collide_final_rs2", 2, 32'h66, 1'b0, 5'd0, 1, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); o = obs[e.step];
         g = (e.port == 1) ? o.p1 : o.p2;
         vectors++;
         if (g.b !== e.busy || (e.chkVal && g.v !== e.val) || (e.chkTag && g.t !== e.tag)) begin
            miscompares++;
            $display("[TB] FAIL %s: got val=%h busy=%0b tag=%0d, want val=%h busy=%0b tag=%0d",
                     e.name, g.v, g.b, g.t, e.val, e.busy, e.tag);
         end
      end
      obs.delete();
   endtask

   task automatic test_flush();
      port_obs_t g;
      step_obs_t o;
      exp_t e;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd10, 1'b0, 1'b1, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd11, 1'b0, 1'b1, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd12, 1'b0, 1'b1, 5'd0, 5'd0);
      look(5'd1, 5'd3);
      want("flush_pre_x1", 1, 32'h0, 1'b1, 5'd10, 0, 1);
      want("flush_pre_x3", 2, 32'h0, 1'b1, 5'd12, 0, 1);
      drive(1'b1, 5'd10, 5'd1, 32'h10, 1'b1, 5'd8, 5'd4, 1'b1, 1'b1, 5'd1, 5'd8);
      want("flush_commit_bypass", 1, 32'h10, 1'b0, 5'd0, 1, 0);
      want("flush_x8_same_cycle", 2, 32'h0, 1'b0, 5'd0, 0, 0);
      look(5'd1, 5'd2);
      want("flush_x1", 1, 32'h10, 1'b0, 5'd0, 1, 0);
      want("flush_x2", 2, 32'h0, 1'b0, 5'd0, 1, 0);
      look(5'd3, 5'd8);
      want("flush_x3", 1, 32'h0, 1'b0, 5'd0, 1, 0);
      want("flush_x8_dropped", 2, 32'h0, 1'b0, 5'd0, 1, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); o = obs[e.step];
         g = (e.port == 1) ? o.p1 : o.p2;
         vectors++;
         if (g.b !== e.busy || (e.chkVal && g.v !== e.val) || (e.chkTag && g.t !== e.tag)) begin
            miscompares++;
            $display("[TB] FAIL %s: got val=%h busy=%0b tag=%0d, want val=%h busy=%0b tag=%0d",
                     e.name, g.v, g.b, g.t, e.val, e.busy, e.tag);
         end
      end
      obs.delete();
   endtask

   task automatic test_x0_stall();
      port_obs_t g;
      step_obs_t o;
      exp_t e;
      drive(1'b1, 5'd0, 5'd0, 32'hFF, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0);
      want("x0_same_cycle", 1, 32'h0, 1'b0, 5'd0, 1, 1);
      look(5'd0, 5'd0);
      want("x0_rs1", 1, 32'h0, 1'b0, 5'd0, 1, 1);
      want("x0_rs2", 2, 32'h0, 1'b0, 5'd0, 1, 1);
      drive(1'b1, 5'd0, 5'd5, 32'h77, 1'b1, 5'd9, 5'd7, 1'b0, 1'b0, 5'd9, 5'd5);
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd5);
      want("stall_x9", 1, 32'h0, 1'b0, 5'd0, 1, 0);
      want("stall_x5", 2, 32'hDEADBEEF, 1'b0, 5'd0, 1, 0);
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 1'b0, 1'b1, 5'd9, 5'd5);
      look(5'd9, 5'd5);
      want("unstall_x9", 1, 32'h0, 1'b1, 5'd7, 0, 1);
      want("unstall_x5", 2, 32'hDEADBEEF, 1'b0, 5'd0, 1, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); o = obs[e.step];
         g = (e.port == 1) ? o.p1 : o.p2;
         vectors++;
         if (g.b !== e.busy || (e.chkVal && g.v !== e.val) || (e.chkTag && g.t !== e.tag)) begin
            miscompares++;
            $display("[TB] FAIL %s: got val=%h busy=%0b tag=%0d, want val=%h busy=%0b tag=%0d",
                     e.name, g.v, g.b, g.t, e.val, e.busy, e.tag);
         end
      end
      obs.delete();
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
      commit_en_in = 1'b0; commit_tag_in = '0; commit_rd_in = '0; commit_val_in = '0;
      rename_en_in = 1'b0; rename_rd_in = '0; rename_tag_in = '0;
      rs1_addr_in = '0; rs2_addr_in = '0;
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_collision();
      test_flush();
      test_x0_stall();
      look(5'd0, 5'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
